// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-adder cell computes a + ~b + 1 LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Handshake: start is sampled on a rising edge only while ready=1; done is a
  // one-cycle pulse during which diff/borrow/ovf are already valid and then held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             sum_bit, carry_out;
  logic [WIDTH-1:0] acc_next;

  assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign carry_out = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  assign acc_next  = {sum_bit, acc_q[WIDTH-1:1]};

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    sa_d     = sa_q;
    sb_d     = sb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
`endif
        end
      end
      CALC: begin
        carry_d = carry_out;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        acc_d   = acc_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Result is latched from the final bit so it is valid while done is high.
          state_d  = DONE;
          diff_d   = acc_next;
          borrow_d = ~carry_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d    = (sa_q != sb_q) && (sum_bit != sa_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): vector table plus handshake, hold, back-to-back and reset-abort sequences.
module tb_serial_subtractor;
  localparam int W = 4;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, borrow, ovf;
  logic [W-1:0] diff;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = 0;
  logic [W-1:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver: wait (bounded) for ready, present operands, let one edge accept them.
  task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready), 32'd1);
    a = ai;
    b = bi;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("ready_drop", 32'(ready), 32'd0);
  endtask

  // Expects W busy cycles (already in cycle 1 after accept), then a done cycle with results.
  task automatic expect_result(input logic [W-1:0] ed, input logic ebr, input logic eov, input bit scramble);
    int busy_n = 0;
    logic [W-1:0] exp_d;
    exp_q.push_back(ed);
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      if (busy && !done) busy_n++;
      if (scramble) begin
        a = W'($urandom_range(0, 15));
        b = W'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    exp_d = exp_q.pop_front();
    chk("busy_cycles", 32'(busy_n), 32'(W));
    chk("done_pulse", 32'(done), 32'd1);
    chk("diff", 32'(diff), 32'(exp_d));
    chk("borrow", 32'(borrow), 32'(ebr));
    chk("ovf", 32'(ovf), 32'(eov & OVF_ON));
    done_cyc = cyc;
  endtask

  vec_t vecs[9];
  int c1, bad, nd;

  initial begin
    vecs[0] = '{a: 4'd7,  b: 4'd3,  d: 4'd4,  br: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd7,  d: 4'hC,  br: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 4'd0,  b: 4'd1,  d: 4'hF,  br: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 4'h8,  b: 4'h1,  d: 4'h7,  br: 1'b0, ov: 1'b1};
    vecs[4] = '{a: 4'h2,  b: 4'h1,  d: 4'h1,  br: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 4'd5,  b: 4'hA,  d: 4'hB,  br: 1'b1, ov: 1'b1};
    vecs[6] = '{a: 4'hF,  b: 4'h0,  d: 4'hF,  br: 1'b0, ov: 1'b0};
    vecs[7] = '{a: 4'd6,  b: 4'd6,  d: 4'h0,  br: 1'b0, ov: 1'b0};
    vecs[8] = '{a: 4'h7,  b: 4'hF,  d: 4'h8,  br: 1'b1, ov: 1'b1};

    // Reset state
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 7-3 with timing, then 3-7 with a 20-cycle hold check
    launch(4'd7, 4'd3, 1'b0);
    expect_result(4'd4, 1'b0, 1'b0, 1'b1);
    launch(4'd3, 4'd7, 1'b0);
    expect_result(4'hC, 1'b1, 1'b0, 1'b0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a = W'($urandom_range(0, 15));
      if (diff !== 4'hC || borrow !== 1'b1 || done !== 1'b0) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);

    // Back-to-back: 0-0 then 15-15 on the first ready cycle
    launch(4'd0, 4'd0, 1'b0);
    expect_result(4'd0, 1'b0, 1'b0, 1'b0);
    c1 = done_cyc;
    launch(4'd15, 4'd15, 1'b0);
    expect_result(4'd0, 1'b0, 1'b0, 1'b0);
    chk("b2b_spacing", 32'(done_cyc - c1), 32'(W + 2));

    // start held high through 9-2; the next accept happens as ready returns
    launch(4'd9, 4'd2, 1'b1);
    expect_result(4'd7, 1'b0, 1'b1, 1'b1);
    c1 = done_cyc;
    a = 4'd4;
    b = 4'd1;
    launch(4'd4, 4'd1, 1'b0);
    expect_result(4'd3, 1'b0, 1'b0, 1'b0);
    chk("held_start_spacing", 32'(done_cyc - c1), 32'(W + 2));

    // Reset asserted on the 2nd CALC cycle of 12-5
    launch(4'd12, 4'd5, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    nd = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    launch(4'd12, 4'd5, 1'b0);
    expect_result(4'd7, 1'b0, 1'b1, 1'b0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, 1'b0);
      expect_result(vecs[i].d, vecs[i].br, vecs[i].ov, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
